rlink_cext_port: RTL and testbench

Device-side endpoint of the simulated rlink byte channel. It consumes the 32-bit rx stream produced by `rlink_cext_iface` and buffers it for the rlink core. It also buffers core transmit bytes and emits them as `tx_data`/`tx_ena` pulses, with a programmable minimum spacing that models link bandwidth. It sits between `rlink_cext_iface` and the rlink core inside `tbcore_rlink`-based test benches, is synthesizable, and also supports FPGA loopback tests.

---
 rtl/rlink_cext_port_pkg.sv | 11 +
 rtl/rlink_cext_port_fifo.sv | 48 ++++
 rtl/rlink_cext_port.sv | 120 ++++++++++++
 tb/tb_rlink_cext_port.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rlink_cext_port_pkg.sv
// Shared types and constants for the rlink channel endpoint.
package rlink_cext_port_pkg;

    typedef enum logic [0:0] {
        S_IDLE,
        S_GAP
    } tx_state_e;

    localparam int unsigned CNT_WIDTH = 16;

endpackage

// File: rtl/rlink_cext_port_fifo.sv
// Synchronous byte FIFO with 2**AWIDTH entries; head is the oldest byte.
module rlink_cext_port_fifo #(
    parameter int unsigned AWIDTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);

    localparam int unsigned DEPTH = 1 << AWIDTH;
    localparam logic [AWIDTH:0] PTR_ONE = 1;

    logic [7:0]      mem [DEPTH];
    logic [AWIDTH:0] wr_ptr_q;
    logic [AWIDTH:0] rd_ptr_q;
    logic            do_push;
    logic            do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign full  = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                   (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AWIDTH-1:0]] <= push_data;
    end

    assign head = mem[rd_ptr_q[AWIDTH-1:0]];

endmodule

// File: rtl/rlink_cext_port.sv
// Device-side rlink channel endpoint: rx/tx byte buffering with throttled tx strobes.
module rlink_cext_port
    import rlink_cext_port_pkg::*;
#(
    parameter int unsigned AWIDTH = 4,
    parameter int unsigned TXGAP  = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          rx_data,
    input  logic                 rx_val,
    output logic                 rx_hold,
    output logic [7:0]           tx_data,
    output logic                 tx_ena,
    output logic [7:0]           rxd_data,
    output logic                 rxd_val,
    input  logic                 rxd_hold,
    input  logic [7:0]           txs_data,
    input  logic                 txs_ena,
    output logic                 txs_busy,
    output logic [CNT_WIDTH-1:0] rx_count,
    output logic [CNT_WIDTH-1:0] tx_count
);

    localparam int unsigned GW = (TXGAP > 1) ? $clog2(TXGAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'((TXGAP > 0) ? TXGAP - 1 : 0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic                 rx_full, rx_empty, rx_push;
    logic [7:0]           rx_head;
    logic                 tx_full, tx_empty, tx_pop;
    logic [7:0]           tx_head;
    tx_state_e            state_q, state_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic                 tx_ena_q;
    logic [7:0]           tx_data_q;
    logic [CNT_WIDTH-1:0] rx_count_q, tx_count_q;
    logic                 unused_rx_bits;

    assign unused_rx_bits = ^rx_data[31:8];

    assign rx_hold  = rx_full | reset;
    assign rx_push  = rx_val & ~rx_hold;
    assign rxd_val  = ~rx_empty;
    assign rxd_data = rx_empty ? 8'h00 : rx_head;
    assign txs_busy = tx_full;

    rlink_cext_port_fifo #(
        .AWIDTH (AWIDTH)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_data[7:0]),
        .pop       (~rxd_hold),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    rlink_cext_port_fifo #(
        .AWIDTH (AWIDTH)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (txs_ena),
        .push_data (txs_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        tx_pop  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop = 1'b1;
                    if (TXGAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            gap_q      <= '0;
            tx_ena_q   <= 1'b0;
            tx_data_q  <= '0;
            rx_count_q <= '0;
            tx_count_q <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            tx_ena_q <= tx_pop;
            if (tx_pop) begin
                tx_data_q  <= tx_head;
                tx_count_q <= tx_count_q + CNT_ONE;
            end
            if (rx_push) rx_count_q <= rx_count_q + CNT_ONE;
        end
    end

    assign tx_ena   = tx_ena_q;
    assign tx_data  = tx_data_q;
    assign rx_count = rx_count_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_rlink_cext_port.sv
// Scoreboard bench for rlink_cext_port with AWIDTH=2, TXGAP=3.
module tb_rlink_cext_port;

    localparam int unsigned AW  = 2;
    localparam int unsigned GAP = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rx_data;
    logic        rx_val;
    logic        rx_hold;
    logic [7:0]  tx_data;
    logic        tx_ena;
    logic [7:0]  rxd_data;
    logic        rxd_val;
    logic        rxd_hold;
    logic [7:0]  txs_data;
    logic        txs_ena;
    logic        txs_busy;
    logic [15:0] rx_count;
    logic [15:0] tx_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];
    int         tx_times[$];
    logic [7:0] rx_e, tx_e;

    rlink_cext_port #(
        .AWIDTH (AW),
        .TXGAP  (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_val   (rx_val),
        .rx_hold  (rx_hold),
        .tx_data  (tx_data),
        .tx_ena   (tx_ena),
        .rxd_data (rxd_data),
        .rxd_val  (rxd_val),
        .rxd_hold (rxd_hold),
        .txs_data (txs_data),
        .txs_ena  (txs_ena),
        .txs_busy (txs_busy),
        .rx_count (rx_count),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitors: pop the scoreboards whenever the DUT delivers a byte.
    always @(negedge clk) begin
        if (rxd_val === 1'b1 && rxd_hold === 1'b0 && reset === 1'b0) begin
            total++;
            if (rx_exp.size() == 0) begin
                bad++;
                $display("FAIL rx_unexpected got=%02h want=none", rxd_data);
            end else begin
                rx_e = rx_exp.pop_front();
                if (rxd_data !== rx_e) begin
                    bad++;
                    $display("FAIL rx_data got=%02h want=%02h", rxd_data, rx_e);
                end
            end
        end
        if (tx_ena === 1'b1) begin
            total++;
            tx_times.push_back(cyc);
            if (tx_exp.size() == 0) begin
                bad++;
                $display("FAIL tx_unexpected got=%02h want=none", tx_data);
            end else begin
                tx_e = tx_exp.pop_front();
                if (tx_data !== tx_e) begin
                    bad++;
                    $display("FAIL tx_data got=%02h want=%02h", tx_data, tx_e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_val   = 1'b0;
        txs_ena  = 1'b0;
        rxd_hold = 1'b0;
        step();
        step();
        rx_exp.delete();
        tx_exp.delete();
        tx_times.delete();
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        rx_val   = 1'b0;
        rx_data  = '0;
        txs_ena  = 1'b0;
        txs_data = '0;
        rxd_hold = 1'b0;
        step();
        step();
        @(negedge clk);
        total += 8;
        if (rx_hold !== 1'b1) begin bad++; $display("FAIL rst_rx_hold got=%b want=1", rx_hold); end
        if (rxd_val !== 1'b0) begin bad++; $display("FAIL rst_rxd_val got=%b want=0", rxd_val); end
        if (rxd_data !== 8'h00) begin bad++; $display("FAIL rst_rxd_data got=%02h want=00", rxd_data); end
        if (tx_ena !== 1'b0) begin bad++; $display("FAIL rst_tx_ena got=%b want=0", tx_ena); end
        if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data got=%02h want=00", tx_data); end
        if (txs_busy !== 1'b0) begin bad++; $display("FAIL rst_txs_busy got=%b want=0", txs_busy); end
        if (rx_count !== 16'h0) begin bad++; $display("FAIL rst_rx_count got=%0h want=0", rx_count); end
        if (tx_count !== 16'h0) begin bad++; $display("FAIL rst_tx_count got=%0h want=0", tx_count); end
        reset = 1'b0;
        step();
        @(negedge clk);
        total++;
        if (rx_hold !== 1'b0) begin bad++; $display("FAIL rst_rx_hold_rel got=%b want=0", rx_hold); end
        step();
    endtask

    task automatic test_rx_stream();
        int k;
        do_reset();
        k = 0;
        for (int c = 0; c < 20 && k < 5; c++) begin
            rx_val  = 1'b1;
            rx_data = {24'hA5A5A5, 8'(k + 1)};
            @(negedge clk);
            if (c < 2) begin
                total++;
                if (rxd_val !== (c == 1)) begin
                    bad++;
                    $display("FAIL rx_latency cycle=%0d got=%b want=%b", c, rxd_val, c == 1);
                end
            end
            if (rx_hold === 1'b0) begin
                rx_exp.push_back(8'(k + 1));
                k++;
            end
            step();
        end
        rx_val = 1'b0;
        for (int c = 0; c < 10 && rx_exp.size() > 0; c++) step();
        @(negedge clk);
        total += 3;
        if (k !== 5) begin bad++; $display("FAIL rx_stream_accepts got=%0d want=5", k); end
        if (rx_exp.size() != 0) begin bad++; $display("FAIL rx_stream_drain got=%0d want=0", rx_exp.size()); end
        if (rx_count !== 16'd5) begin bad++; $display("FAIL rx_stream_count got=%0d want=5", rx_count); end
        step();
    endtask

    task automatic test_rx_full();
        int k;
        logic exp_h;
        do_reset();
        rxd_hold = 1'b1;
        k = 0;
        for (int c = 0; c < 6; c++) begin
            rx_val  = 1'b1;
            rx_data = {24'h0, 8'h30 + 8'(k)};
            exp_h   = (c >= 4);
            @(negedge clk);
            total++;
            if (rx_hold !== exp_h) begin
                bad++;
                $display("FAIL rx_full_hold cycle=%0d got=%b want=%b", c, rx_hold, exp_h);
            end
            if (rx_hold === 1'b0) begin
                rx_exp.push_back(8'h30 + 8'(k));
                k++;
            end
            step();
        end
        @(negedge clk);
        total++;
        if (rx_count !== 16'd4) begin bad++; $display("FAIL rx_full_count got=%0d want=4", rx_count); end
        rxd_hold = 1'b0;
        step();
        for (int c = 0; c < 30 && (k < 6 || rx_exp.size() > 0); c++) begin
            rx_val  = (k < 6);
            rx_data = {24'h0, 8'h30 + 8'(k)};
            @(negedge clk);
            if (k < 6 && rx_hold === 1'b0) begin
                rx_exp.push_back(8'h30 + 8'(k));
                k++;
            end
            step();
        end
        rx_val = 1'b0;
        @(negedge clk);
        total += 2;
        if (rx_exp.size() != 0) begin bad++; $display("FAIL rx_full_drain got=%0d want=0", rx_exp.size()); end
        if (rx_count !== 16'd6) begin bad++; $display("FAIL rx_full_total got=%0d want=6", rx_count); end
        step();
    endtask

    task automatic test_tx_throttle();
        int p0;
        do_reset();
        p0 = 0;
        for (int i = 0; i < 3; i++) begin
            txs_ena  = 1'b1;
            txs_data = 8'hA0 + 8'(i);
            tx_exp.push_back(8'hA0 + 8'(i));
            step();
            if (i == 0) p0 = cyc;
        end
        txs_ena = 1'b0;
        for (int c = 0; c < 40 && tx_times.size() < 3; c++) step();
        @(negedge clk);
        total += 6;
        if (tx_times.size() != 3) begin
            bad += 4;
            $display("FAIL tx_throttle_pulses got=%0d want=3", tx_times.size());
        end else begin
            if (tx_times[0] != p0 + 1) begin
                bad++; $display("FAIL tx_first_latency got=%0d want=%0d", tx_times[0] - p0, 1);
            end
            if (tx_times[1] - tx_times[0] != int'(GAP) + 1) begin
                bad++; $display("FAIL tx_gap01 got=%0d want=%0d", tx_times[1] - tx_times[0], GAP + 1);
            end
            if (tx_times[2] - tx_times[1] != int'(GAP) + 1) begin
                bad++; $display("FAIL tx_gap12 got=%0d want=%0d", tx_times[2] - tx_times[1], GAP + 1);
            end
        end
        if (tx_count !== 16'd3) begin bad++; $display("FAIL tx_throttle_count got=%0d want=3", tx_count); end
        if (tx_data !== 8'hA2) begin bad++; $display("FAIL tx_data_hold got=%02h want=a2", tx_data); end
        step();
    endtask

    task automatic test_tx_full();
        logic [7:0] exp_busy;
        do_reset();
        // With a 4-deep FIFO and a 4-cycle pop period, offers 5 and 7 hit a full FIFO.
        exp_busy = 8'b1010_0000;
        for (int i = 0; i < 8; i++) begin
            txs_ena  = 1'b1;
            txs_data = 8'h50 + 8'(i);
            @(negedge clk);
            total++;
            if (txs_busy !== exp_busy[i]) begin
                bad++;
                $display("FAIL tx_full_busy offer=%0d got=%b want=%b", i, txs_busy, exp_busy[i]);
            end
            if (exp_busy[i] == 1'b0) tx_exp.push_back(8'h50 + 8'(i));
            step();
        end
        txs_ena = 1'b0;
        for (int c = 0; c < 60 && tx_exp.size() > 0; c++) step();
        for (int c = 0; c < 8; c++) step();
        @(negedge clk);
        total += 3;
        if (tx_exp.size() != 0) begin bad++; $display("FAIL tx_full_drain got=%0d want=0", tx_exp.size()); end
        if (tx_times.size() != 6) begin bad++; $display("FAIL tx_full_pulses got=%0d want=6", tx_times.size()); end
        if (tx_count !== 16'd6) begin bad++; $display("FAIL tx_full_count got=%0d want=6", tx_count); end
        step();
    endtask

    task automatic test_wrap();
        int k;
        do_reset();
        k = 0;
        for (int c = 0; c < 70000 && k < 65537; c++) begin
            rx_val  = 1'b1;
            rx_data = {24'h0, 8'(k)};
            @(negedge clk);
            if (rx_hold === 1'b0) begin
                rx_exp.push_back(8'(k));
                k++;
            end
            step();
        end
        rx_val = 1'b0;
        step();
        step();
        @(negedge clk);
        total += 3;
        if (k != 65537) begin bad++; $display("FAIL wrap_accepts got=%0d want=65537", k); end
        if (rx_count !== 16'h0001) begin bad++; $display("FAIL wrap_count got=%04h want=0001", rx_count); end
        if (rx_exp.size() != 0) begin bad++; $display("FAIL wrap_drain got=%0d want=0", rx_exp.size()); end
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        rxd_hold = 1'b1;
        // Leaves 3 bytes in each FIFO with the tx FSM in its gap.
        for (int i = 0; i < 4; i++) begin
            rx_val  = (i < 3);
            rx_data = {24'h0, 8'h70 + 8'(i)};
            if (i < 3) rx_exp.push_back(8'h70 + 8'(i));
            txs_ena  = 1'b1;
            txs_data = 8'h80 + 8'(i);
            tx_exp.push_back(8'h80 + 8'(i));
            step();
        end
        reset   = 1'b1;
        rx_val  = 1'b0;
        txs_ena = 1'b0;
        step();
        @(negedge clk);
        total += 6;
        if (rxd_val !== 1'b0) begin bad++; $display("FAIL mid_rxd_val got=%b want=0", rxd_val); end
        if (tx_ena !== 1'b0) begin bad++; $display("FAIL mid_tx_ena got=%b want=0", tx_ena); end
        if (rx_count !== 16'h0) begin bad++; $display("FAIL mid_rx_count got=%0d want=0", rx_count); end
        if (tx_count !== 16'h0) begin bad++; $display("FAIL mid_tx_count got=%0d want=0", tx_count); end
        if (rx_hold !== 1'b1) begin bad++; $display("FAIL mid_rx_hold got=%b want=1", rx_hold); end
        if (txs_busy !== 1'b0) begin bad++; $display("FAIL mid_txs_busy got=%b want=0", txs_busy); end
        rx_exp.delete();
        tx_exp.delete();
        tx_times.delete();
        reset    = 1'b0;
        rxd_hold = 1'b0;
        rx_val   = 1'b1;
        rx_data  = {24'h0, 8'h99};
        txs_ena  = 1'b1;
        txs_data = 8'h77;
        rx_exp.push_back(8'h99);
        tx_exp.push_back(8'h77);
        #1;
        total++;
        if (rx_hold !== 1'b0) begin bad++; $display("FAIL mid_rel_hold got=%b want=0", rx_hold); end
        step();
        rx_val  = 1'b0;
        txs_ena = 1'b0;
        @(negedge clk);
        total += 3;
        if (rxd_val !== 1'b1) begin bad++; $display("FAIL mid_new_rxd_val got=%b want=1", rxd_val); end
        if (rxd_data !== 8'h99) begin bad++; $display("FAIL mid_new_rxd_data got=%02h want=99", rxd_data); end
        if (tx_ena !== 1'b0) begin bad++; $display("FAIL mid_new_tx_early got=%b want=0", tx_ena); end
        step();
        @(negedge clk);
        total += 2;
        if (tx_ena !== 1'b1) begin bad++; $display("FAIL mid_new_tx_ena got=%b want=1", tx_ena); end
        if (tx_data !== 8'h77) begin bad++; $display("FAIL mid_new_tx_data got=%02h want=77", tx_data); end
        step();
        step();
        total++;
        if (tx_exp.size() != 0 || rx_exp.size() != 0) begin
            bad++;
            $display("FAIL mid_new_drain got=%0d want=0", tx_exp.size() + rx_exp.size());
        end
    endtask

    initial begin
        test_reset();
        test_rx_stream();
        test_rx_full();
        test_tx_throttle();
        test_tx_full();
        test_reset_mid();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
